// File: rtl/multdiv_stall_ctrl.sv
// Sequencer for the multi-cycle multiply/divide unit plus the pipeline
// stall/bubble controller around it (multdiv freeze and load-use stall).
module multdiv_stall_ctrl #(
    parameter int MD_TIMEOUT   = 40,
    parameter int RSTATUS_REG  = 30,
    parameter int MUL_EXC_CODE = 4,
    parameter int DIV_EXC_CODE = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dx_is_mul,
    input  logic        dx_is_div,
    input  logic [4:0]  dx_rd,
    input  logic        dx_is_lw,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        fd_uses_rs,
    input  logic        fd_uses_rt,
    input  logic        md_result_rdy,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic        stall_pc_fd,
    output logic        stall_dx,
    output logic        bubble_dx,
    output logic        bubble_xm,
    output logic        md_wb,
    output logic [4:0]  md_wb_rd,
    output logic [31:0] md_wb_data,
    output logic        md_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0]  CNT_LAST  = 6'(MD_TIMEOUT - 1);
    localparam logic [4:0]  RSTAT_RD  = 5'(RSTATUS_REG);
    localparam logic [31:0] MUL_CODE  = 32'(MUL_EXC_CODE);
    localparam logic [31:0] DIV_CODE  = 32'(DIV_EXC_CODE);

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic        op_div_reg, op_div_next;
    logic [4:0]  rd_q_reg, rd_q_next;
    logic [31:0] data_q_reg, data_q_next;
    logic        exc_q_reg, exc_q_next;

    logic md_go;
    logic md_stall;
    logic lu_hazard;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_div_reg <= 1'b0;
            rd_q_reg   <= '0;
            data_q_reg <= '0;
            exc_q_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_div_reg <= op_div_next;
            rd_q_reg   <= rd_q_next;
            data_q_reg <= data_q_next;
            exc_q_reg  <= exc_q_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_div_next = op_div_reg;
        rd_q_next   = rd_q_reg;
        data_q_next = data_q_reg;
        exc_q_next  = exc_q_reg;
        md_go       = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                md_go = dx_is_mul | dx_is_div;
                if (md_go) begin
                    op_div_next = dx_is_div;
                    rd_q_next   = dx_rd;
                    cnt_next    = '0;
                    state_next  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real result always beats the timeout in the same cycle.
                if (md_result_rdy) begin
                    data_q_next = md_result;
                    exc_q_next  = md_exception;
                    state_next  = ST_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    exc_q_next = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign md_stall  = md_go | (state_reg == ST_BUSY);
    assign lu_hazard = ~md_stall & dx_is_lw & (dx_rd != 5'd0) &
                       ((fd_uses_rs & (fd_rs == dx_rd)) |
                        (fd_uses_rt & (fd_rt == dx_rd)));

    // Mealy terms are gated with reset_n so nothing leaks out during reset.
    always_comb begin
        md_ctrl_mult = reset_n & md_go & ~dx_is_div;
        md_ctrl_div  = reset_n & md_go & dx_is_div;
        stall_pc_fd  = reset_n & (md_stall | lu_hazard);
        stall_dx     = reset_n & md_stall;
        bubble_xm    = reset_n & md_stall;
        bubble_dx    = reset_n & lu_hazard;
        md_busy      = (state_reg == ST_BUSY);
        md_wb        = (state_reg == ST_DONE);
        md_wb_rd     = '0;
        md_wb_data   = '0;
        if (state_reg == ST_DONE) begin
            md_wb_rd   = exc_q_reg ? RSTAT_RD : rd_q_reg;
            md_wb_data = exc_q_reg ? (op_div_reg ? DIV_CODE : MUL_CODE) : data_q_reg;
        end
    end

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Directed bench for multdiv_stall_ctrl: a cycle-level model of the
// launch/freeze/write-back rules checked every cycle, plus literal pins.
module tb_multdiv_stall_ctrl;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        dx_is_mul = 1'b0, dx_is_div = 1'b0, dx_is_lw = 1'b0;
    logic [4:0]  dx_rd = '0, fd_rs = '0, fd_rt = '0;
    logic        fd_uses_rs = 1'b0, fd_uses_rt = 1'b0;
    logic        md_result_rdy = 1'b0, md_exception = 1'b0;
    logic [31:0] md_result = '0;
    logic        md_ctrl_mult, md_ctrl_div, stall_pc_fd, stall_dx;
    logic        bubble_dx, bubble_xm, md_wb, md_busy;
    logic [4:0]  md_wb_rd;
    logic [31:0] md_wb_data;

    int vectors = 0;
    int miscompares = 0;

    multdiv_stall_ctrl #(
        .MD_TIMEOUT(TMO), .RSTATUS_REG(30), .MUL_EXC_CODE(4), .DIV_EXC_CODE(5)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .dx_is_mul(dx_is_mul), .dx_is_div(dx_is_div), .dx_rd(dx_rd),
        .dx_is_lw(dx_is_lw), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .md_result_rdy(md_result_rdy), .md_exception(md_exception),
        .md_result(md_result),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .stall_pc_fd(stall_pc_fd), .stall_dx(stall_dx),
        .bubble_dx(bubble_dx), .bubble_xm(bubble_xm),
        .md_wb(md_wb), .md_wb_rd(md_wb_rd), .md_wb_data(md_wb_data),
        .md_busy(md_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Model: in-flight op aged in cycles since launch, one pending write-back.
    bit          m_fl = 0, m_wb = 0, m_div = 0, m_exc = 0;
    int          m_age = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    bit          e_go, e_st, e_lu;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_mult", md_ctrl_mult, 0);
            chk("rst_div", md_ctrl_div, 0);
            chk("rst_stall_pc_fd", stall_pc_fd, 0);
            chk("rst_stall_dx", stall_dx, 0);
            chk("rst_bubble_dx", bubble_dx, 0);
            chk("rst_bubble_xm", bubble_xm, 0);
            chk("rst_md_wb", md_wb, 0);
            chk("rst_md_busy", md_busy, 0);
            chk("rst_wb_rd", 32'(md_wb_rd), 0);
            chk("rst_wb_data", md_wb_data, 0);
            m_fl = 0; m_wb = 0; m_div = 0; m_exc = 0; m_age = 0; m_rd = '0; m_data = '0;
        end else begin
            e_go = !m_fl && !m_wb && (dx_is_mul || dx_is_div);
            e_st = e_go || m_fl;
            e_lu = !e_st && dx_is_lw && dx_rd != 0 &&
                   ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
            chk("md_ctrl_mult", md_ctrl_mult, 32'(e_go && !dx_is_div));
            chk("md_ctrl_div", md_ctrl_div, 32'(e_go && dx_is_div));
            chk("stall_pc_fd", stall_pc_fd, 32'(e_st || e_lu));
            chk("stall_dx", stall_dx, 32'(e_st));
            chk("bubble_xm", bubble_xm, 32'(e_st));
            chk("bubble_dx", bubble_dx, 32'(e_lu));
            chk("md_busy", md_busy, 32'(m_fl));
            chk("md_wb", md_wb, 32'(m_wb));
            if (m_wb) begin
                chk("md_wb_rd", 32'(md_wb_rd), m_exc ? 32'd30 : 32'(m_rd));
                chk("md_wb_data", md_wb_data, m_exc ? (m_div ? 32'd5 : 32'd4) : m_data);
            end
            if (m_wb) begin
                m_wb = 0;
            end else if (m_fl) begin
                if (md_result_rdy) begin
                    m_fl = 0; m_wb = 1; m_exc = md_exception; m_data = md_result;
                end else if (m_age == TMO) begin
                    m_fl = 0; m_wb = 1; m_exc = 1;
                end else begin
                    m_age++;
                end
            end else if (e_go) begin
                m_fl = 1; m_age = 1; m_div = dx_is_div; m_rd = dx_rd;
            end
        end
    end

    // k>0: result on cycle L+k; k==0: never arrives (timeout).
    task automatic run_md(input bit div, input logic [4:0] rd, input int k, input bit exc,
                          input logic [31:0] res, input logic [4:0] exp_rd,
                          input logic [31:0] exp_data, input bit next_div);
        int n;
        n = (k > 0) ? k : TMO;
        step();
        dx_is_mul = !div; dx_is_div = div; dx_rd = rd;
        @(negedge clock);
        chk("launch_pulse", div ? 32'(md_ctrl_div) : 32'(md_ctrl_mult), 1);
        for (int i = 1; i <= n; i++) begin
            step();
            md_result_rdy = (k > 0 && i == k);
            md_exception = exc;
            md_result = res;
            @(negedge clock);
            chk("freeze", 32'(stall_pc_fd & stall_dx & bubble_xm), 1);
        end
        step();
        md_result_rdy = 0; md_exception = 0; md_result = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("done_wb", md_wb, 1);
        chk("done_rd", 32'(md_wb_rd), 32'(exp_rd));
        chk("done_data", md_wb_data, exp_data);
        chk("done_no_stall", 32'(stall_dx | stall_pc_fd), 0);
        $display("txn %s rd=%0d k=%0d exc=%0d -> wb_rd=%0d wb_data=0x%0h",
                 div ? "DIV" : "MUL", rd, k, exc, md_wb_rd, md_wb_data);
        step();
        dx_is_mul = 0; dx_is_div = next_div; dx_rd = 5'd9;
        @(negedge clock);
        if (next_div) begin
            chk("b2b_div_launch", md_ctrl_div, 1);
        end else begin
            chk("idle_busy", md_busy, 0);
            chk("idle_wb", md_wb, 0);
        end
    endtask

    initial begin
        // Reset with MUL in DX, rd=0 write-back still asserted.
        dx_is_mul = 1; dx_rd = 0;
        repeat (2) @(negedge clock);
        chk("in_reset_mult", md_ctrl_mult, 0);
        @(posedge clock); #1; reset_n = 1;
        @(negedge clock);
        chk("release_mult", md_ctrl_mult, 1);
        step(); dx_is_mul = 0;
        step(); md_result_rdy = 1; md_result = 32'h77;
        step(); md_result_rdy = 0;
        @(negedge clock);
        chk("r0_wb", md_wb, 1);
        chk("r0_wb_rd", 32'(md_wb_rd), 0);
        $display("txn MUL rd=0 after reset -> wb_rd=%0d wb_data=0x%0h", md_wb_rd, md_wb_data);
        step();

        run_md(0, 5'd5, 3, 0, 32'h2A, 5'd5, 32'h2A, 0);
        run_md(1, 5'd12, 2, 1, 32'h1234, 5'd30, 32'd5, 0);
        run_md(0, 5'd12, 2, 1, 32'h1234, 5'd30, 32'd4, 0);
        run_md(0, 5'd3, 0, 0, 32'h0, 5'd30, 32'd4, 0);
        run_md(1, 5'd3, 0, 0, 32'h0, 5'd30, 32'd5, 0);
        run_md(0, 5'd8, 1, 0, 32'hFFFF_0001, 5'd8, 32'hFFFF_0001, 0);

        // Load-use hazards.
        step(); dx_is_lw = 1; dx_rd = 7; fd_rs = 7; fd_uses_rs = 1;
        @(negedge clock);
        chk("lu_stall", 32'({stall_pc_fd, bubble_dx, stall_dx, bubble_xm}), 32'b1100);
        $display("txn LW rd=7 rs=7 -> stall_pc_fd=%0d bubble_dx=%0d", stall_pc_fd, bubble_dx);
        step(); dx_rd = 0; fd_rs = 0;
        @(negedge clock);
        chk("lu_r0", 32'(stall_pc_fd | bubble_dx), 0);
        step(); dx_rd = 7; fd_rs = 7; fd_uses_rs = 0;
        @(negedge clock);
        chk("lu_unused", 32'(stall_pc_fd | bubble_dx), 0);
        step(); fd_rt = 7; fd_uses_rt = 1;
        @(negedge clock);
        chk("lu_rt", 32'(bubble_dx), 1);
        step(); dx_is_lw = 0; fd_uses_rt = 0;

        // Back-to-back MUL then DIV, reset in the middle of the DIV.
        run_md(0, 5'd4, 2, 0, 32'h99, 5'd4, 32'h99, 1);
        step(); step();
        step(); reset_n = 0;
        @(negedge clock);
        chk("midbusy_rst", 32'(stall_dx | md_busy | md_ctrl_div), 0);
        step(); reset_n = 1;
        @(negedge clock);
        chk("relaunch_div", md_ctrl_div, 1);
        chk("no_stale_wb", md_wb, 0);
        step(); dx_is_div = 1;
        step(); md_result_rdy = 1; md_result = 32'h64;
        step(); md_result_rdy = 0; dx_is_div = 0;
        @(negedge clock);
        chk("relaunch_wb_rd", 32'(md_wb_rd), 9);
        chk("relaunch_wb_data", md_wb_data, 32'h64);
        $display("txn DIV rd=9 relaunched -> wb_rd=%0d wb_data=0x%0h", md_wb_rd, md_wb_data);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/multdiv_stall_ctrl.md
# multdiv_stall_ctrl

Sequencer for the multi-cycle multiply/divide unit and the pipeline stall/bubble controller that surrounds it. It sits beside the forwarding logic at the DX/XM boundary. It launches a MUL/DIV held in DX, freezes the front of the pipeline while the unit iterates, and captures the result or exception. When done, it hands a single write-back to the XM latch. It also raises the one-cycle load-use stall that forwarding cannot cover, because a LW in DX has no data until MW.

## Interface
- MD_TIMEOUT, 40: BUSY cycles before the unit is declared hung; must be 2..63.
- RSTATUS_REG, 30: destination register for exception codes.
- MUL_EXC_CODE, 4: rstatus value for a multiply overflow or timeout.
- DIV_EXC_CODE, 5: rstatus value for a divide-by-zero or timeout.

Ports:
- clock  in  1  system clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dx_is_mul  in  1  DX holds a valid MUL (ALU op 00110).
- dx_is_div  in  1  DX holds a valid DIV (ALU op 00111).
- dx_rd  in  5  DX destination register.
- dx_is_lw  in  1  DX holds a LW with register write enabled.
- fd_rs, fd_rt  in  5 each  source registers of the FD instruction.
- fd_uses_rs, fd_uses_rt  in  1 each  FD instruction actually reads that source.
- md_result_rdy  in  1  multdiv result valid (pulse).
- md_exception  in  1  multdiv exception; qualified by md_result_rdy.
- md_result  in  32  multdiv result; qualified by md_result_rdy.
- md_ctrl_mult, md_ctrl_div  out  1 each  one-cycle start pulses to the unit.
- stall_pc_fd  out  1  hold the PC and FD latch.
- stall_dx  out  1  hold the DX latch.
- bubble_dx  out  1  load a nop into DX.
- bubble_xm  out  1  load a nop into XM.
- md_wb  out  1  override the XM latch with md_wb_rd / md_wb_data this cycle.
- md_wb_rd  out  5  write-back destination.
- md_wb_data  out  32  write-back value.
- md_busy  out  1  state is BUSY.

## Operation
**States:** IDLE, BUSY, DONE (2-bit register). The block also holds a 6-bit counter `cnt`, a latched op `op_div`, a latched `rd_q`, `data_q[31:0]` and `exc_q`.

**md_go** = state==IDLE & (dx_is_mul | dx_is_div). When both inputs are high, DIV wins.

**IDLE**
- If md_go:
  - Pulse md_ctrl_mult or md_ctrl_div this cycle (Mealy).
  - Latch op_div and rd_q=dx_rd; clear cnt.
  - Go to BUSY.

**BUSY**
- md_result_rdy=1, checked first:
  - data_q=md_result, exc_q=md_exception.
  - Go to DONE.
- Else if cnt==MD_TIMEOUT-1:
  - exc_q=1; go to DONE.
- Else cnt+1.

**DONE**
- md_wb=1 for exactly one cycle, then go to IDLE.
- Write-back when exc_q=0: md_wb_rd=rd_q, md_wb_data=data_q.
- Write-back when exc_q=1: md_wb_rd=RSTATUS_REG, md_wb_data=DIV_EXC_CODE if op_div else MUL_EXC_CODE (zero-extended).
- A second MUL/DIV already in DX launches no earlier than the IDLE cycle that follows DONE.

**Multdiv stall**
- md_stall = md_go | state==BUSY.
- While md_stall:
  - stall_pc_fd=1, stall_dx=1, bubble_xm=1.
  - bubble_dx=0.
- In DONE all stalls are 0: the MUL/DIV moves DX→XM and md_wb supplies its payload.

**Load-use stall**
- lu = dx_is_lw & dx_rd!=0 & ((fd_uses_rs & fd_rs==dx_rd) | (fd_uses_rt & fd_rt==dx_rd)).
- lu is suppressed while md_stall.
- When lu:
  - stall_pc_fd=1, bubble_dx=1, for one cycle.
  - stall_dx=0, bubble_xm=0.

**General rules**
- rd_q==0 with no exception: md_wb is still asserted, with md_wb_rd=0; $r0 protection stays in the register file.
- reset_n low: state=IDLE, cnt=0, rd_q=0, data_q=0, exc_q=0, op_div=0. Every output is forced to 0 while reset_n is low, including the Mealy outputs.

## Timing
- Launch cycle is L, result first seen on md_result_rdy in cycle L+k (k≥1):
  - Stall asserted cycles L..L+k.
  - DONE at L+k+1 with md_wb=1.
  - IDLE at L+k+2.
- Total freeze is k+1 cycles; write-back latency is k+1 cycles from the launch.
- md_result_rdy in the launch cycle (IDLE) is ignored.
- md_result_rdy outside BUSY is ignored.
- Timeout: rdy never arrives → DONE at L+MD_TIMEOUT+1, exception write-back.
- Reset asserted mid-BUSY: outputs 0 immediately. After release the block is in IDLE; a MUL/DIV still in DX relaunches.
- md_busy is registered, derived from state only.

## Test plan
- Reset: reset_n=0 with dx_is_mul=1 → all outputs 0. Release → md_ctrl_mult=1 in the first clocked cycle.
- MUL rd=5, rdy at L+3 with md_result=0x0000002A:
  - stall_pc_fd/stall_dx/bubble_xm high for L..L+3.
  - L+4: md_wb=1, rd=5, data=0x2A.
  - L+5: idle.
- DIV with md_exception=1 at rdy → md_wb_rd=30, md_wb_data=5. Same stimulus on a MUL → data 4.
- Timeout with MD_TIMEOUT=4, rdy never asserted → DONE at L+5, md_wb_rd=30, code per op.
- Load-use: dx_is_lw=1, dx_rd=7, fd_rs=7, fd_uses_rs=1 → one cycle of stall_pc_fd=1, bubble_dx=1, stall_dx=0. With dx_rd=0 or fd_uses_rs=0 → no stall.
- Back-to-back MUL then DIV; reset pulsed mid-BUSY on the DIV → DIV relaunches after release with md_ctrl_div, and there is no stale md_wb.
